// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencing FSM for a subtract-and-compare GCD datapath.
// Operands arrive one after the other on the shared data_in bus via a
// valid/ready handshake. The larger register is reduced by the smaller
// until they match. An iteration limit bounds runtime so that a zero
// operand cannot hang the unit.
module gcd_ctrl #(
  parameter int unsigned MAX_ITER = 65535,
  parameter int unsigned ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              eq,
  input  logic              lt,
  input  logic              gt,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    FIN,
    FAIL
  } state_e;

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              done_q, err_q;

  // Next-state logic and Mealy datapath controls, decoded from the state and the comparator flags
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    op_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          iter_d  = '0;
        end
      end
      LOAD_A: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ldA     = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        op_ready = 1'b1;
        if (op_valid) begin
          ldB     = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // The limit check comes before any increment, so the counter cannot wrap
        if (eq) begin
          state_d = FIN;
        end else if (iter_q == MaxIter) begin
          state_d = FAIL;
        end else if (lt) begin
          sel1   = 1'b1;
          sel_in = 1'b1;
          ldB    = 1'b1;
          iter_d = iter_q + ITER_W'(1);
        end else if (gt) begin
          sel2   = 1'b1;
          sel_in = 1'b1;
          ldA    = 1'b1;
          iter_d = iter_q + ITER_W'(1);
        end else begin
          state_d = FAIL;
        end
      end
      FIN:     state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, iteration counter and registered completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      done_q  <= (state_d == FIN);
      err_q   <= (state_d == FAIL);
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: drives gcd_ctrl together with a behavioural GCD datapath,
// queues expected completions and checks them from an independent monitor.
module tb_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        eq, lt, gt;
  logic        ldA, ldB, sel1, sel2, sel_in;
  logic        busy, done, err;
  logic [15:0] iter_count;

  logic [15:0] dataIn = '0;
  logic [15:0] regA = '0;
  logic [15:0] regB = '0;
  logic [15:0] muxL, muxR, diff, bus;
  logic        forceNone = 1'b0;

  int total = 0;
  int bad = 0;
  int busyCycles = 0;
  int subLoads = 0;
  int subLoadsB = 0;

  typedef struct {
    bit          isErr;
    logic [15:0] res;
    logic [15:0] iter;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  gcd_ctrl #(.MAX_ITER(16), .ITER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid),
    .op_ready(op_ready), .eq(eq), .lt(lt), .gt(gt),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  // Behavioural datapath: muxes, subtractor and comparator
  always_comb begin
    muxL = sel1 ? regB : regA;
    muxR = sel2 ? regB : regA;
    diff = muxL - muxR;
    bus  = sel_in ? diff : dataIn;
    eq   = !forceNone && (regA == regB);
    lt   = !forceNone && (regA < regB);
    gt   = !forceNone && (regA > regB);
  end

  // Datapath registers and load counters
  always @(posedge clk) begin
    if (ldA) regA <= bus;
    if (ldB) regB <= bus;
    if ((ldA || ldB) && sel_in) subLoads <= subLoads + 1;
    if (ldB && sel_in) subLoadsB <= subLoadsB + 1;
  end

  always @(negedge clk) begin
    if (busy) busyCycles <= busyCycles + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pops the oldest expectation whenever the DUT reports completion
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (done || err)) begin
      checkOutput("doneErrExclusive", {31'd0, done && err}, 32'd0);
      checkOutput("pendingExpect", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("kindErr", {31'd0, err}, {31'd0, e.isErr});
        checkOutput("iterCount", {16'd0, iter_count}, {16'd0, e.iter});
        if (!e.isErr) begin
          checkOutput("resultA", {16'd0, regA}, {16'd0, e.res});
          checkOutput("resultB", {16'd0, regB}, {16'd0, e.res});
        end
      end
    end
  end

  // One complete operation; expected busy length is 4 + stalls + subtractions
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int stallA, input int stallB,
                               input bit pokeStart, input bit forceFlags,
                               input bit expErr, input logic [15:0] expRes,
                               input logic [15:0] expIter);
    exp_t e;
    int busySnap, subSnap, subBSnap;
    bit seen;
    e.isErr = expErr;
    e.res   = expRes;
    e.iter  = expIter;
    sb.push_back(e);
    busySnap = busyCycles;
    subSnap  = subLoads;
    subBSnap = subLoadsB;
    @(posedge clk); #1;
    start    = 1'b1;
    dataIn   = a;
    op_valid = (stallA == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < stallA; i++) begin
      @(negedge clk);
      checkOutput("stallReadyA", {31'd0, op_ready}, 32'd1);
      checkOutput("stallNoLoadA", {30'd0, ldA, ldB}, 32'd0);
      @(posedge clk); #1;
    end
    op_valid = 1'b1;
    @(posedge clk); #1;
    dataIn   = b;
    op_valid = (stallB == 0);
    for (int i = 0; i < stallB; i++) begin
      @(negedge clk);
      checkOutput("stallReadyB", {31'd0, op_ready}, 32'd1);
      checkOutput("stallNoLoadB", {30'd0, ldA, ldB}, 32'd0);
      @(posedge clk); #1;
    end
    op_valid = 1'b1;
    @(posedge clk); #1;
    if (forceFlags) forceNone = 1'b1;
    if (pokeStart) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    checkOutput("completionSeen", {31'd0, seen}, 32'd1);
    if (pokeStart) start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    forceNone = 1'b0;
    @(negedge clk); #1;
    checkOutput("backToIdle", {31'd0, busy}, 32'd0);
    checkOutput("noStrayPulse", {30'd0, done, err}, 32'd0);
    checkOutput("busyCycles", busyCycles - busySnap, 4 + stallA + stallB + expIter);
    checkOutput("subLoads", subLoads - subSnap, {16'd0, expIter});
    if (a == 16'd0) checkOutput("subLoadsB", subLoadsB - subBSnap, {16'd0, expIter});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetPulses", {30'd0, done, err}, 32'd0);
    checkOutput("resetIter", {16'd0, iter_count}, 32'd0);
    checkOutput("resetControls", {26'd0, op_ready, ldA, ldB, sel1, sel2, sel_in}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleHold", {31'd0, busy}, 32'd0);

    // gt,gt,lt,gt -> 6 after 4 subtractions
    applyStimulus(16'd48, 16'd18, 0, 0, 1'b0, 1'b0, 1'b0, 16'd6, 16'd4);
    // equal operands finish with no subtraction
    applyStimulus(16'd7, 16'd7, 0, 0, 1'b0, 1'b0, 1'b0, 16'd7, 16'd0);
    // handshake stalls: 35,14 -> 21,14 -> 7,14 -> 7,7
    applyStimulus(16'd35, 16'd14, 3, 2, 1'b0, 1'b0, 1'b0, 16'd7, 16'd3);
    // zero operand runs into the limit of 16
    applyStimulus(16'd0, 16'd5, 0, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd16);
    // exactly 16 subtractions still completes because eq wins over the limit
    applyStimulus(16'd17, 16'd1, 0, 0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd16);
    // one more subtraction needed than allowed
    applyStimulus(16'd18, 16'd1, 0, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd16);
    // both zero -> equal immediately, result 0
    applyStimulus(16'd0, 16'd0, 0, 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    // Asynchronous reset in the middle of GCD(1000,3)
    @(posedge clk); #1;
    start = 1'b1; op_valid = 1'b1; dataIn = 16'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dataIn = 16'd3;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midCalcIter", {16'd0, iter_count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncPulses", {30'd0, done, err}, 32'd0);
    checkOutput("asyncIter", {16'd0, iter_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd12, 16'd8, 0, 0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd2);

    // start pulses in CALC and in FIN are ignored: 21,6 -> 15,9,3 then 3,3
    applyStimulus(16'd21, 16'd6, 0, 0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd4);
    // no comparator flag asserted in CALC -> abort
    applyStimulus(16'd9, 16'd6, 0, 0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
